// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: NOP encoding, fetch FSM
// state encodings, default reset vector and a word-alignment helper.
package cpu_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are cleared.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous active-low reset to RESET_PC,
// load has priority over increment, +4 wraps modulo 2^32.
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        inc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Select the next PC: redirect load wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_plus4;
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory, buffers a word across stalls and squashes fetches
// that were in flight when a branch/jump redirect arrived.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        stallstall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCadd4,
    output logic [31:0] IF_Inst,
    output logic        IF_Valid
);

    fetch_state_e state_q;
    logic [31:0]  inst_buf_q;
    logic [31:0]  pending_q;

    logic         en;
    logic [31:0]  target;
    logic         pc_load;
    logic [31:0]  pc_load_val;
    logic         pc_inc;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;

    // Same enable as the IF/ID register, so a handed-over word is never lost.
    assign en     = ~stall & ~stallstall;
    assign target = word_align(Redirect_PC);

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (pc_load),
        .load_pc_i  (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    // PC control: a redirect target (or the pending one, once the squashed
    // fetch completes) is loaded; otherwise advance on an accepted hand-over.
    always_comb begin
        pc_load     = 1'b0;
        pc_load_val = target;
        pc_inc      = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (Redirect) begin
                    pc_load = imem_ack;
                end else begin
                    pc_inc = imem_ack & en;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    pc_load = 1'b1;
                end else begin
                    pc_inc = en;
                end
            end
            ST_DROP: begin
                pc_load     = imem_ack;
                pc_load_val = Redirect ? target : pending_q;
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    // Fetch FSM with instruction buffer and pending redirect target.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_FETCH;
            inst_buf_q <= NOP_INST;
            pending_q  <= 32'h0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (Redirect) begin
                        if (!imem_ack) begin
                            pending_q <= target;
                            state_q   <= ST_DROP;
                        end
                    end else if (imem_ack && !en) begin
                        inst_buf_q <= imem_rdata;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (Redirect || en) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (Redirect) begin
                        pending_q <= target;
                    end
                    if (imem_ack) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Memory-side and PC outputs; reset forces the idle/reset-vector view.
    always_comb begin
        imem_req  = Reset && (state_q != ST_HOLD);
        imem_addr = Reset ? pc       : RESET_PC;
        IF_PC     = Reset ? pc       : RESET_PC;
        IF_PCadd4 = Reset ? pc_plus4 : (RESET_PC + 32'd4);
    end

    // Instruction presented to IF/ID: pass-through on ack, buffer in HOLD,
    // bubble on redirect, squash or reset.
    always_comb begin
        IF_Inst  = NOP_INST;
        IF_Valid = 1'b0;
        if (Reset && !Redirect) begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        IF_Inst  = imem_rdata;
                        IF_Valid = 1'b1;
                    end
                end
                ST_HOLD: begin
                    IF_Inst  = inst_buf_q;
                    IF_Valid = 1'b1;
                end
                default: begin
                    IF_Valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Memory returns {16'hA5A5, addr[15:0]}.
module tb_if_fetch_unit;

    logic        clk;
    logic        Reset;
    logic        stall;
    logic        stallstall;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCadd4;
    logic [31:0] IF_Inst;
    logic        IF_Valid;

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .Clk         (clk),
        .Reset       (Reset),
        .stall       (stall),
        .stallstall  (stallstall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IF_PC       (IF_PC),
        .IF_PCadd4   (IF_PCadd4),
        .IF_Inst     (IF_Inst),
        .IF_Valid    (IF_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        Reset = 1'b0; stall = 1'b0; stallstall = 1'b0;
        Redirect = 1'b0; Redirect_PC = 32'h0; imem_ack = 1'b1;

        // Reset state (ack high must not leak through).
        nxt(); nxt(); settle();
        chk("rst_req",    {31'h0, imem_req}, 32'h0);
        chk("rst_addr",   imem_addr, 32'h0000_3000);
        chk("rst_pc",     IF_PC, 32'h0000_3000);
        chk("rst_pcadd4", IF_PCadd4, 32'h0000_3004);
        chk("rst_inst",   IF_Inst, 32'h0);
        chk("rst_valid",  {31'h0, IF_Valid}, 32'h0);

        // Zero-wait stream.
        Reset = 1'b1; settle();
        chk("zw0_req",   {31'h0, imem_req}, 32'h1);
        chk("zw0_pc",    IF_PC, 32'h0000_3000);
        chk("zw0_inst",  IF_Inst, 32'hA5A5_3000);
        chk("zw0_valid", {31'h0, IF_Valid}, 32'h1);
        nxt();
        chk("zw1_pc",    IF_PC, 32'h0000_3004);
        chk("zw1_inst",  IF_Inst, 32'hA5A5_3004);
        chk("zw1_valid", {31'h0, IF_Valid}, 32'h1);
        nxt();
        chk("zw2_pc",    IF_PC, 32'h0000_3008);
        chk("zw2_add4",  IF_PCadd4, 32'h0000_300C);
        chk("zw2_valid", {31'h0, IF_Valid}, 32'h1);
        nxt();

        // Wait states: two bubble cycles, then ack at 300C.
        imem_ack = 1'b0; settle();
        chk("ws0_addr",  imem_addr, 32'h0000_300C);
        chk("ws0_inst",  IF_Inst, 32'h0);
        chk("ws0_valid", {31'h0, IF_Valid}, 32'h0);
        nxt();
        chk("ws1_req",   {31'h0, imem_req}, 32'h1);
        chk("ws1_addr",  imem_addr, 32'h0000_300C);
        chk("ws1_valid", {31'h0, IF_Valid}, 32'h0);
        nxt();
        imem_ack = 1'b1; settle();
        chk("ws2_addr",  imem_addr, 32'h0000_300C);
        chk("ws2_inst",  IF_Inst, 32'hA5A5_300C);
        chk("ws2_valid", {31'h0, IF_Valid}, 32'h1);
        nxt();

        // Stall in the ack cycle at 3010, held for 4 cycles.
        stall = 1'b1; settle();
        chk("st0_addr", imem_addr, 32'h0000_3010);
        nxt();
        imem_ack = 1'b0; settle();
        for (int i = 0; i < 3; i++) begin
            chk("st_hold_req",   {31'h0, imem_req}, 32'h0);
            chk("st_hold_inst",  IF_Inst, 32'hA5A5_3010);
            chk("st_hold_valid", {31'h0, IF_Valid}, 32'h1);
            chk("st_hold_pc",    IF_PC, 32'h0000_3010);
            if (i < 2) nxt();
        end
        nxt();
        stall = 1'b0; settle();
        chk("st4_req",  {31'h0, imem_req}, 32'h0);
        chk("st4_inst", IF_Inst, 32'hA5A5_3010);
        nxt();
        imem_ack = 1'b1; settle();
        chk("st5_req",  {31'h0, imem_req}, 32'h1);
        chk("st5_addr", imem_addr, 32'h0000_3014);
        chk("st5_inst", IF_Inst, 32'hA5A5_3014);
        nxt(); nxt(); nxt();

        // Redirect to 4003 with request at 3020 outstanding.
        imem_ack = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h0000_4003; settle();
        chk("rd0_addr",  imem_addr, 32'h0000_3020);
        chk("rd0_valid", {31'h0, IF_Valid}, 32'h0);
        chk("rd0_inst",  IF_Inst, 32'h0);
        nxt();
        Redirect = 1'b0; settle();
        chk("rd1_req",   {31'h0, imem_req}, 32'h1);
        chk("rd1_addr",  imem_addr, 32'h0000_3020);
        chk("rd1_valid", {31'h0, IF_Valid}, 32'h0);
        nxt();
        imem_ack = 1'b1; settle();
        chk("rd2_addr",  imem_addr, 32'h0000_3020);
        chk("rd2_valid", {31'h0, IF_Valid}, 32'h0);
        chk("rd2_inst",  IF_Inst, 32'h0);
        nxt();
        chk("rd3_addr",  imem_addr, 32'h0000_4000);
        chk("rd3_pc",    IF_PC, 32'h0000_4000);
        chk("rd3_inst",  IF_Inst, 32'hA5A5_4000);
        chk("rd3_valid", {31'h0, IF_Valid}, 32'h1);
        nxt();

        // Double redirect while dropping: 5000 then 6000.
        imem_ack = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h0000_5000;
        nxt();
        Redirect_PC = 32'h0000_6000; settle();
        chk("dd1_addr", imem_addr, 32'h0000_4004);
        chk("dd1_req",  {31'h0, imem_req}, 32'h1);
        nxt();
        Redirect = 1'b0; imem_ack = 1'b1; settle();
        chk("dd2_valid", {31'h0, IF_Valid}, 32'h0);
        nxt();
        chk("dd3_addr", imem_addr, 32'h0000_6000);
        chk("dd3_inst", IF_Inst, 32'hA5A5_6000);
        nxt();

        // Redirect during stall wins.
        stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h0000_7000; settle();
        chk("rs0_inst",  IF_Inst, 32'h0);
        chk("rs0_valid", {31'h0, IF_Valid}, 32'h0);
        nxt();
        stall = 1'b0; Redirect = 1'b0; imem_ack = 1'b0; settle();
        chk("rs1_addr", imem_addr, 32'h0000_7000);
        chk("rs1_req",  {31'h0, imem_req}, 32'h1);

        // Reset in DROP.
        Redirect = 1'b1; Redirect_PC = 32'h0000_8000;
        nxt();
        Redirect = 1'b0; Reset = 1'b0; settle();
        chk("rm0_req",  {31'h0, imem_req}, 32'h0);
        chk("rm0_addr", imem_addr, 32'h0000_3000);
        chk("rm0_pc",   IF_PC, 32'h0000_3000);
        nxt();
        chk("rm1_req",  {31'h0, imem_req}, 32'h0);
        nxt();
        Reset = 1'b1; imem_ack = 1'b1; settle();
        chk("rm2_addr",  imem_addr, 32'h0000_3000);
        chk("rm2_valid", {31'h0, IF_Valid}, 32'h1);
        chk("rm2_inst",  IF_Inst, 32'hA5A5_3000);
        nxt();

        // Wrap-around via redirect to FFFF_FFFC.
        Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
        nxt();
        Redirect = 1'b0; settle();
        chk("wr0_pc",    IF_PC, 32'hFFFF_FFFC);
        chk("wr0_add4",  IF_PCadd4, 32'h0);
        chk("wr0_inst",  IF_Inst, 32'hA5A5_FFFC);
        nxt();
        chk("wr1_addr",  imem_addr, 32'h0);
        chk("wr1_pc",    IF_PC, 32'h0);
        chk("wr1_inst",  IF_Inst, 32'hA5A5_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
